// File: rtl/counter_ctrl_if.sv
// Control/status bundle between the key/switch front end and the counter sequencer.
// Master drives the key pulses and switch levels; slave returns the count and run status.
interface counter_ctrl_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  start_i;
  logic                  load_i;
  logic                  step_i;
  logic                  dir_i;
  logic [DATA_WIDTH-1:0] load_val_i;
  logic [DATA_WIDTH-1:0] limit_i;
  logic [DATA_WIDTH-1:0] cnt_o;
  logic                  run_o;
  logic                  wrap_o;
  logic [1:0]            state_o;

  modport master (
    output start_i, load_i, step_i, dir_i, load_val_i, limit_i,
    input  cnt_o, run_o, wrap_o, state_o
  );

  modport slave (
    input  start_i, load_i, step_i, dir_i, load_val_i, limit_i,
    output cnt_o, run_o, wrap_o, state_o
  );
endinterface

// File: rtl/counter_ctrl.sv
// Run-control sequencer for the display counter: timed up/down count, pause, preset, wrap pulse.
// Latency: one clk100_i edge from a sampled pulse to registered outputs; auto steps every TICK_DIV cycles.
// No backpressure: pulses act in the cycle sampled. COUNTER_CTRL_LIMIT_EN adds stop-at-limit (DONE).
module counter_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int TICK_DIV   = 10_000_000
) (
  input  logic              clk100_i,
  input  logic              rst_i,
  counter_ctrl_if.slave     bus
);

  localparam int PRE_W = $clog2(TICK_DIV);
  localparam logic [PRE_W-1:0]      PRE_LAST = PRE_W'(TICK_DIV - 1);
  localparam logic [DATA_WIDTH-1:0] ONE      = DATA_WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_t;

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
  logic [PRE_W-1:0]      pre_q, pre_d;
  logic                  run_q, wrap_q, wrap_d;
  logic                  tick, step_en, wrap_hit;
  logic [DATA_WIDTH-1:0] step_val;

  always_ff @(posedge clk100_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pre_q   <= '0;
      run_q   <= 1'b0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pre_q   <= pre_d;
      run_q   <= (state_d == RUN);
      wrap_q  <= wrap_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    step_en  = 1'b0;
    tick     = (state_q == RUN) && (pre_q == PRE_LAST);
    step_val = bus.dir_i ? (cnt_q - ONE) : (cnt_q + ONE);
    wrap_hit = bus.dir_i ? (cnt_q == '0) : (&cnt_q);

    unique case (state_q)
      IDLE: begin
        if (bus.start_i) state_d = RUN;
        step_en = bus.step_i;
      end
      RUN: begin
        // a pause request swallows the tick that lands in the same cycle
        if (bus.start_i) state_d = PAUSE;
        else             step_en = tick;
      end
      PAUSE: begin
        if (bus.start_i) state_d = RUN;
        step_en = bus.step_i;
      end
      default: begin
`ifdef COUNTER_CTRL_LIMIT_EN
        if (bus.start_i)     state_d = RUN;
        else if (bus.load_i) state_d = IDLE;
`else
        state_d = IDLE;
`endif
      end
    endcase

    if (bus.load_i) step_en = 1'b0;

`ifdef COUNTER_CTRL_LIMIT_EN
    // only a step can stop the count; a preset equal to the limit does not
    if (step_en && (step_val == bus.limit_i)) state_d = DONE;
`endif

    if (bus.load_i)   cnt_d = bus.load_val_i;
    else if (step_en) cnt_d = step_val;
    else              cnt_d = cnt_q;

    wrap_d = step_en && wrap_hit;

    // prescaler restarts on RUN entry, on load and after each tick
    pre_d = '0;
    if ((state_q == RUN) && (state_d == RUN) && !bus.load_i && !tick)
      pre_d = pre_q + PRE_W'(1);
  end

`ifndef COUNTER_CTRL_LIMIT_EN
  logic unused_limit;
  assign unused_limit = ^bus.limit_i;
`endif

  assign bus.cnt_o   = cnt_q;
  assign bus.run_o   = run_q;
  assign bus.wrap_o  = wrap_q;
  assign bus.state_o = state_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Scoreboard bench for counter_ctrl with TICK_DIV=4: per-edge expected outputs queued at drive time,
// popped and compared after each edge, plus directed checkpoints from the test plan.
module tb_counter_ctrl;

  localparam int TICK = 4;
  localparam logic [1:0] S_IDLE = 2'b00, S_RUN = 2'b01, S_PAUSE = 2'b10, S_DONE = 2'b11;

  typedef struct packed {
    logic [7:0] cnt;
    logic [1:0] st;
    logic       run;
    logic       wrap;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic dir = 1'b0;
  logic [7:0] limit = 8'h80;

  int total = 0;
  int bad   = 0;

  exp_t sb[$];

  logic [7:0] m_cnt  = 8'h00;
  logic [1:0] m_st   = S_IDLE;
  int         m_pre  = 0;
  logic       m_wrap = 1'b0;

  counter_ctrl_if #(.DATA_WIDTH(8)) bus ();

  counter_ctrl #(.DATA_WIDTH(8), .TICK_DIV(TICK)) dut (
    .clk100_i (clk),
    .rst_i    (rst),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Behavioural reference for one edge given the currently driven inputs.
  task automatic model_edge(input logic s, input logic l, input logic st, input logic [7:0] v);
    logic [7:0] nxt;
    logic [1:0] ns;
    logic       tick, dstep;
    int         np;
    if (rst) begin
      m_cnt = 8'h00; m_st = S_IDLE; m_pre = 0; m_wrap = 1'b0;
    end else begin
      tick  = (m_st == S_RUN) && (m_pre == TICK - 1);
      dstep = !l && (((m_st == S_IDLE || m_st == S_PAUSE) && st) || (tick && !s));
      ns = m_st;
      if (s)                       ns = (m_st == S_RUN) ? S_PAUSE : S_RUN;
      else if (l && m_st == S_DONE) ns = S_IDLE;
      nxt    = dir ? m_cnt - 8'd1 : m_cnt + 8'd1;
      m_wrap = dstep && (dir ? (m_cnt == 8'h00) : (m_cnt == 8'hFF));
`ifdef COUNTER_CTRL_LIMIT_EN
      if (dstep && nxt == limit) ns = S_DONE;
`endif
      np = (m_st == S_RUN && ns == S_RUN && !l && !tick) ? m_pre + 1 : 0;
      if (l)          m_cnt = v;
      else if (dstep) m_cnt = nxt;
      m_st  = ns;
      m_pre = np;
    end
    sb.push_back('{cnt: m_cnt, st: m_st, run: (m_st == S_RUN), wrap: m_wrap});
  endtask

  task automatic cyc(input logic s, input logic l, input logic st, input logic [7:0] v);
    exp_t e;
    @(negedge clk);
    bus.start_i    = s;
    bus.load_i     = l;
    bus.step_i     = st;
    bus.dir_i      = dir;
    bus.load_val_i = v;
    bus.limit_i    = limit;
    model_edge(s, l, st, v);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      chk("sb_cnt",  {24'd0, bus.cnt_o},   {24'd0, e.cnt});
      chk("sb_st",   {30'd0, bus.state_o}, {30'd0, e.st});
      chk("sb_run",  {31'd0, bus.run_o},   {31'd0, e.run});
      chk("sb_wrap", {31'd0, bus.wrap_o},  {31'd0, e.wrap});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  initial begin
    bus.start_i = 1'b0; bus.load_i = 1'b0; bus.step_i = 1'b0;
    bus.dir_i = 1'b0; bus.load_val_i = 8'h00; bus.limit_i = limit;

    // reset from power-up
    idle(2);
    chk("rst_cnt", {24'd0, bus.cnt_o}, 32'h00);
    chk("rst_st",  {30'd0, bus.state_o}, {30'd0, S_IDLE});
    rst = 1'b0;

    // timed run: start at E0, steps at E0+4 and E0+8
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    idle(3);
    chk("run_e3", {24'd0, bus.cnt_o}, 32'h00);
    idle(1);
    chk("run_e4", {24'd0, bus.cnt_o}, 32'h01);
    idle(4);
    chk("run_e8", {24'd0, bus.cnt_o}, 32'h02);
    chk("run_st", {30'd0, bus.state_o}, {30'd0, S_RUN});
    chk("run_o",  {31'd0, bus.run_o}, 32'd1);

    // reset mid-RUN at 0x37
    cyc(1'b0, 1'b1, 1'b0, 8'h37);
    idle(1);
    chk("pre_rst_cnt", {24'd0, bus.cnt_o}, 32'h37);
    rst = 1'b1;
    idle(1);
    chk("mrst_cnt",  {24'd0, bus.cnt_o}, 32'h00);
    chk("mrst_st",   {30'd0, bus.state_o}, {30'd0, S_IDLE});
    chk("mrst_run",  {31'd0, bus.run_o}, 32'd0);
    chk("mrst_wrap", {31'd0, bus.wrap_o}, 32'd0);
    idle(1);
    rst = 1'b0;

    // wrap up: FE -> FF -> 00 with a one-cycle wrap pulse
    cyc(1'b0, 1'b1, 1'b0, 8'hFE);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    idle(4);
    chk("wu_ff",   {24'd0, bus.cnt_o}, 32'hFF);
    chk("wu_nw",   {31'd0, bus.wrap_o}, 32'd0);
    idle(4);
    chk("wu_00",   {24'd0, bus.cnt_o}, 32'h00);
    chk("wu_wrap", {31'd0, bus.wrap_o}, 32'd1);
    idle(1);
    chk("wu_drop", {31'd0, bus.wrap_o}, 32'd0);

    // step down from 0 in PAUSE, then step ignored in RUN
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    chk("pause_st", {30'd0, bus.state_o}, {30'd0, S_PAUSE});
    dir = 1'b1;
    cyc(1'b0, 1'b0, 1'b1, 8'h00);
    chk("sd_ff",   {24'd0, bus.cnt_o}, 32'hFF);
    chk("sd_wrap", {31'd0, bus.wrap_o}, 32'd1);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    cyc(1'b0, 1'b0, 1'b1, 8'h00);
    chk("run_step_ign", {24'd0, bus.cnt_o}, 32'hFF);

    // collision: load 0x42 + start on the tick edge
    idle(2);
    cyc(1'b1, 1'b1, 1'b0, 8'h42);
    chk("col_cnt", {24'd0, bus.cnt_o}, 32'h42);
    chk("col_st",  {30'd0, bus.state_o}, {30'd0, S_PAUSE});
    idle(4);
    chk("col_hold", {24'd0, bus.cnt_o}, 32'h42);

    // limit at 0x05
    dir = 1'b0;
    limit = 8'h05;
    cyc(1'b0, 1'b1, 1'b0, 8'h03);
    cyc(1'b1, 1'b0, 1'b0, 8'h00);
    idle(4);
    chk("lim_04", {24'd0, bus.cnt_o}, 32'h04);
    idle(4);
    chk("lim_05", {24'd0, bus.cnt_o}, 32'h05);
`ifdef COUNTER_CTRL_LIMIT_EN
    chk("lim_st",  {30'd0, bus.state_o}, {30'd0, S_DONE});
    chk("lim_run", {31'd0, bus.run_o}, 32'd0);
    idle(4);
    chk("lim_hold", {24'd0, bus.cnt_o}, 32'h05);
    cyc(1'b0, 1'b1, 1'b0, 8'h05);
    chk("lim_ld_idle", {30'd0, bus.state_o}, {30'd0, S_IDLE});
`else
    chk("lim_st",  {30'd0, bus.state_o}, {30'd0, S_RUN});
    idle(4);
    chk("lim_06", {24'd0, bus.cnt_o}, 32'h06);
    cyc(1'b0, 1'b1, 1'b0, 8'h05);
    chk("lim_ld_run", {30'd0, bus.state_o}, {30'd0, S_RUN});
`endif
    idle(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
